// File: rtl/adc_sample_averager.sv
// rtl/adc_sample_averager.sv - triggers MCP3201 conversions, averages 2^LOG2_AVG samples, valid/ready output
module adc_sample_averager #(
  parameter int SAMPLE_PERIOD = 256,
  parameter int LOG2_AVG      = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        adc_start,
  input  logic        adc_busy,
  input  logic        adc_new_data,
  input  logic [11:0] adc_data,
  output logic [11:0] avg_data,
  output logic        avg_valid,
  input  logic        avg_ready,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        clear_status
);

  localparam int AW = 12 + LOG2_AVG;
  localparam int CW = LOG2_AVG + 1;
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(1 << LOG2_AVG);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    REQ       = 3'd2,
    CONV      = 3'd3,
    ACCUM     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          busy_meta_q, busy_s_q, nd_meta_q, nd_s_q, nd_dly_q;
  logic [PW-1:0] per_q, per_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic [11:0]   avg_data_q, avg_data_d;
  logic          avg_valid_q, avg_valid_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;
  logic          tick, nd_rise, ovr_set, to_set;

  assign tick    = enable && (per_q == PER_LAST);
  assign nd_rise = nd_s_q & ~nd_dly_q;

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    avg_data_d  = avg_data_q;
    avg_valid_d = avg_valid_q;
    ovr_set     = 1'b0;
    to_set      = 1'b0;
    per_d       = (enable && !tick) ? per_q + PW'(1) : '0;

    if (avg_valid_q && avg_ready) avg_valid_d = 1'b0;

    case (state_q)
      IDLE: if (enable) state_d = WAIT_TICK;
      WAIT_TICK: begin
        if (!enable) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (tick) begin
          start_d = 1'b1;
          tcnt_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (busy_s_q) begin
          start_d = 1'b0;
          state_d = CONV;
        end else if (tcnt_q == TO_LAST) begin
          to_set  = 1'b1;
          start_d = 1'b0;
          state_d = WAIT_TICK;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      CONV: begin
        // a missed sample keeps the partial sum; the next tick simply retries
        if (nd_rise) begin
          acc_d   = acc_q + AW'(adc_data);
          cnt_d   = cnt_q + CW'(1);
          state_d = ACCUM;
        end else if (tcnt_q == TO_LAST) begin
          to_set  = 1'b1;
          state_d = WAIT_TICK;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ACCUM: begin
        if (cnt_q == CNT_FULL) begin
          avg_data_d  = acc_q[AW-1:LOG2_AVG];
          avg_valid_d = 1'b1;
          ovr_set     = avg_valid_q && !avg_ready;
          acc_d       = '0;
          cnt_d       = '0;
        end
        state_d = WAIT_TICK;
      end
      default: state_d = IDLE;
    endcase

    overrun_d = ovr_set | (overrun_q & ~clear_status);
    timeout_d = to_set  | (timeout_q & ~clear_status);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
      nd_meta_q   <= 1'b0;
      nd_s_q      <= 1'b0;
      nd_dly_q    <= 1'b0;
      per_q       <= '0;
      tcnt_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      avg_data_q  <= '0;
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_meta_q <= adc_busy;
      busy_s_q    <= busy_meta_q;
      nd_meta_q   <= adc_new_data;
      nd_s_q      <= nd_meta_q;
      nd_dly_q    <= nd_s_q;
      per_q       <= per_d;
      tcnt_q      <= tcnt_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      avg_data_q  <= avg_data_d;
      avg_valid_q <= avg_valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign adc_start   = start_q;
  assign avg_data    = avg_data_q;
  assign avg_valid   = avg_valid_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// tb/tb_adc_sample_averager.sv - directed bench with an MCP3201 reader model
module tb_adc_sample_averager;

  logic        clk = 1'b0;
  logic        rst, enable, adc_start, adc_busy, adc_new_data;
  logic [11:0] adc_data, avg_data;
  logic        avg_valid, avg_ready, overrun, timeout_err, clear_status;

  int errors = 0, checks = 0;
  int cyc = 0, nstarts = 0, last_start = 0, start_gap = 0;
  bit prev_start = 1'b0, mute = 1'b0;
  logic [11:0] sample_q[$];

  typedef struct {
    logic [3:0][11:0] s;
    logic [11:0]      expv;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  adc_sample_averager #(.SAMPLE_PERIOD(256), .LOG2_AVG(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_start(adc_start),
    .adc_busy(adc_busy), .adc_new_data(adc_new_data), .adc_data(adc_data),
    .avg_data(avg_data), .avg_valid(avg_valid), .avg_ready(avg_ready),
    .overrun(overrun), .timeout_err(timeout_err), .clear_status(clear_status)
  );

  // reader model: busy a few cycles after start, data + new_data ~24 cycles later
  initial begin
    adc_busy = 1'b0; adc_new_data = 1'b0; adc_data = '0;
    forever begin
      @(negedge clk);
      if (adc_start && !mute) begin
        adc_new_data = 1'b0;
        repeat (4) @(negedge clk);
        adc_busy = 1'b1;
        repeat (20) @(negedge clk);
        adc_data = (sample_q.size() > 0) ? sample_q.pop_front() : 12'd0;
        adc_busy = 1'b0;
        adc_new_data = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (adc_start && !prev_start) begin
        nstarts++;
        start_gap = cyc - last_start;
        last_start = cyc;
      end
      prev_start = adc_start;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return avg_valid === 1'b1;
      1: return adc_start === 1'b1;
      2: return adc_start === 1'b0;
      3: return overrun === 1'b1;
      4: return dut.acc_q != '0;
      default: return 32'(dut.state_q) == 0;
    endcase
  endfunction

  task automatic wait_cond(input string name, input int which, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cond(which)) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles", name, bound);
  endtask

  initial begin
    int s0, n;
    vecs[0] = '{s: {12'd400, 12'd300, 12'd200, 12'd100}, expv: 12'd250};
    vecs[1] = '{s: {12'd4095, 12'd4095, 12'd4095, 12'd4095}, expv: 12'd4095};
    vecs[2] = '{s: {12'd2, 12'd2, 12'd2, 12'd1}, expv: 12'd1};
    vecs[3] = '{s: {12'd3, 12'd0, 12'd0, 12'd0}, expv: 12'd0};
    vecs[4] = '{s: {12'd8, 12'd7, 12'd6, 12'd5}, expv: 12'd6};

    rst = 1'b1; enable = 1'b0; avg_ready = 1'b1; clear_status = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start", 32'(adc_start), 0);
    check("rst_avg_data", 32'(avg_data), 0);
    check("rst_avg_valid", 32'(avg_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    rst = 1'b0; enable = 1'b1;

    s0 = nstarts;
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 4; k++) sample_q.push_back(vecs[v].s[k]);
      wait_cond("vec_valid", 0, 1400);
      check($sformatf("vec%0d_avg", v), 32'(avg_data), 32'(vecs[v].expv));
      check($sformatf("vec%0d_starts", v), 32'(nstarts - s0), 4);
      check($sformatf("vec%0d_gap", v), 32'(start_gap), 256);
      s0 = nstarts;
      @(negedge clk);
      check($sformatf("vec%0d_valid_drop", v), 32'(avg_valid), 0);
    end

    avg_ready = 1'b0;
    for (int k = 0; k < 8; k++) sample_q.push_back(12'h800);
    wait_cond("ovr_first_valid", 0, 1400);
    check("ovr_first_data", 32'(avg_data), 32'h800);
    check("ovr_not_yet", 32'(overrun), 0);
    wait_cond("ovr_set", 3, 1400);
    check("ovr_data", 32'(avg_data), 32'h800);
    check("ovr_valid_held", 32'(avg_valid), 1);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    check("ovr_cleared", 32'(overrun), 0);
    check("ovr_valid_still", 32'(avg_valid), 1);

    mute = 1'b1;
    wait_cond("to_start", 1, 300);
    n = 0;
    while (adc_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_start_width", 32'(n), 64);
    check("to_err", 32'(timeout_err), 1);
    s0 = nstarts;
    wait_cond("to_retry", 1, 300);
    check("to_retry_start", 32'(nstarts - s0), 1);

    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_start", 32'(adc_start), 0);
    check("arst_valid", 32'(avg_valid), 0);
    check("arst_timeout", 32'(timeout_err), 0);
    check("arst_overrun", 32'(overrun), 0);
    @(negedge clk);
    rst = 1'b0; mute = 1'b0; avg_ready = 1'b1;
    sample_q = {12'd10, 12'd20, 12'd30, 12'd40};
    wait_cond("post_rst_valid", 0, 1400);
    check("post_rst_avg", 32'(avg_data), 25);
    check("post_rst_timeout", 32'(timeout_err), 0);

    sample_q.push_back(12'd50);
    wait_cond("en_start", 1, 300);
    wait_cond("en_conv", 2, 40);
    enable = 1'b0;
    wait_cond("en_capture", 4, 80);
    check("en_acc_captured", 32'(dut.acc_q), 50);
    wait_cond("en_idle", 5, 20);
    check("en_acc_cleared", 32'(dut.acc_q), 0);
    check("en_cnt_cleared", 32'(dut.cnt_q), 0);
    s0 = nstarts;
    repeat (600) @(negedge clk);
    check("en_no_start", 32'(nstarts - s0), 0);
    check("en_state_idle", 32'(dut.state_q), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
